tx_resp_arbiter: RTL and testbench
==================================

Name: tx_resp_arbiter

Overview:
- Shares the single UART transmitter between two response sources in the REF_CLK domain:
  - register-file read data (8-bit);
  - ALU results (16-bit).
- Sits between the controller/register file/ALU outputs and the TX data synchronizer.
- Holds one pending response per source and picks between them round-robin.
- Serializes ALU results as two bytes, LSB first.
- Handshakes each byte against the synchronized UART busy flag.

Parameters:
- TIMEOUT_CYC, 1024, REF_CLK cycles to wait for TX_BUSY to rise after TX_VLD asserts (used only with the optional feature).
- CNT_W, 11, width of the timeout counter. Must hold TIMEOUT_CYC.

Ports:
- CLK  in  1  REF_CLK domain clock
- RST  in  1  asynchronous active-low reset
- RD_DATA  in  8  register-file read data
- RD_DATA_VLD  in  1  single-cycle valid for RD_DATA
- ALU_OUT  in  16  ALU result
- ALU_OUT_VLD  in  1  single-cycle valid for ALU_OUT
- TX_BUSY  in  1  UART busy, already synchronized to CLK
- OVF_CLR  in  1  synchronous clear of OVF_ERR and TO_ERR
- TX_DATA  out  8  byte presented to the TX synchronizer
- TX_VLD  out  1  level request. Held until TX_BUSY is seen high.
- OVF_ERR  out  1  sticky: a request was dropped because its slot was full
- TO_ERR  out  1  sticky: a handshake timed out
- ARB_BUSY  out  1  high when any slot is pending or the FSM is not IDLE

Behaviour:
- Reset (RST=0, async):
  - FSM goes to IDLE.
  - Both slots empty; round-robin pointer set to RD.
  - TX_DATA=0, TX_VLD=0, OVF_ERR=0, TO_ERR=0, ARB_BUSY=0.
  - Reset during a transfer abandons it. No retry after release.
- Slots:
  - rd_slot {8b data, pend} and alu_slot {16b data, pend}.
  - A valid pulse with the slot empty captures the data and sets pend the next cycle.
  - A valid pulse with pend=1 and the slot not being granted that cycle: new data is dropped, the old data is kept, and OVF_ERR is set.
  - A slot is freed in its grant cycle. A valid pulse in that same cycle is accepted, with no overflow.
- Arbitration happens only in IDLE with TX_BUSY=0:
  - One slot pending: grant it.
  - Both pending: grant the source opposite the pointer's last grant.
  - The pointer updates on each grant.
- FSM states: IDLE, REQ, DRAIN.
  - IDLE→REQ on grant. Next cycle: TX_DATA = granted byte (RD data, or ALU[7:0]), TX_VLD=1. The grant→TX_VLD latency is 1 cycle.
  - REQ: TX_VLD and TX_DATA are held stable. When TX_BUSY=1: TX_VLD=0, go to DRAIN.
  - DRAIN: wait for TX_BUSY=0.
    - If the granted source was ALU and the MSB is still owed: TX_DATA = ALU[15:8], TX_VLD=1, go to REQ (same cycle busy falls is registered, so TX_VLD rises the next cycle).
    - Otherwise go to IDLE.
  - The ALU MSB byte always follows its LSB back-to-back. An RD request never interleaves between them.
- TX_BUSY already high in IDLE (left over from a previous transfer) blocks any grant until it falls.
- ARB_BUSY = rd_pend | alu_pend | (state != IDLE).
- OVF_CLR clears both sticky flags. A same-cycle set wins over the clear.

Optional Feature:
- Macro: TX_RESP_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT_CYC with TX_BUSY still 0: TX_VLD=0, TO_ERR=1, the current byte and any remaining MSB byte are discarded, and the FSM goes to IDLE.
- Not defined:
  - No counter is built; TO_ERR is tied to 0.
  - REQ waits indefinitely for TX_BUSY.

Test Plan:
- RD_DATA=0x5A pulse, TX_BUSY model rises 4 cycles after TX_VLD and is high 20 cycles → TX_DATA=0x5A, TX_VLD high exactly until the first TX_BUSY=1 cycle, one byte total, ARB_BUSY low after busy falls.
- ALU_OUT=0xBEEF pulse → bytes 0xEF then 0xBE, the second TX_VLD asserted the cycle after TX_BUSY falls, with no gap for an arbitration cycle.
- RD 0x11 and ALU 0x2233 pulsed in the same cycle after reset → byte order 0x11, 0x33, 0x22. Repeat with both pending after an RD grant → ALU is served first.
- Two RD pulses (0x01, 0x02) while the first is still pending → 0x01 is sent, 0x02 is dropped, OVF_ERR=1. OVF_CLR clears it. A pulse in the grant cycle is accepted with no overflow.
- RST asserted mid-REQ of an ALU LSB → all outputs zero immediately. After release, no MSB byte is sent.
- With TX_RESP_TIMEOUT_EN, TIMEOUT_CYC=16, TX_BUSY held 0 → TX_VLD drops after 16 REQ cycles and TO_ERR=1. Without the macro, TX_VLD stays high and TO_ERR stays 0.

Source files
------------

// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter sharing the UART transmitter between register-file reads and ALU results.
// Optional TX handshake timeout is enabled by defining TX_RESP_TIMEOUT_EN.
module tx_resp_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rd_data_i,
    input  logic        rd_data_vld_i,
    input  logic [15:0] alu_out_i,
    input  logic        alu_out_vld_i,
    input  logic        tx_busy_i,
    input  logic        ovf_clr_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_vld_o,
    output logic        ovf_err_o,
    output logic        to_err_o,
    output logic        arb_busy_o
);

    typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

    state_e      state_q, state_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        rd_pend_q, rd_pend_d;
    logic [15:0] alu_data_q, alu_data_d;
    logic        alu_pend_q, alu_pend_d;
    logic        prio_rd_q, prio_rd_d;
    logic [7:0]  msb_q, msb_d;
    logic        msb_owed_q, msb_owed_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_vld_q, tx_vld_d;
    logic        ovf_q, ovf_d;
    logic        to_q, to_d;
    logic        grant_rd, grant_alu;
    logic        ovf_rd, ovf_alu;
    logic        to_set;
    logic        timeout;

`ifdef TX_RESP_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter restarts on every entry to REQ, including the MSB byte re-entry from DRAIN.
    always_comb begin
        cnt_d = '0;
        if (state_q == StReq) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == StReq) && !tx_busy_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYC, CNT_W};
    assign timeout    = 1'b0;
`endif

    // prio_rd_q names the source that wins when both slots are pending.
    always_comb begin
        grant_rd  = 1'b0;
        grant_alu = 1'b0;
        if ((state_q == StIdle) && !tx_busy_i) begin
            if (rd_pend_q && alu_pend_q) begin
                grant_rd  = prio_rd_q;
                grant_alu = !prio_rd_q;
            end else begin
                grant_rd  = rd_pend_q;
                grant_alu = alu_pend_q;
            end
        end
    end

    always_comb begin
        rd_pend_d = rd_pend_q & ~grant_rd;
        rd_data_d = rd_data_q;
        ovf_rd    = 1'b0;
        if (rd_data_vld_i) begin
            if (!rd_pend_d) begin
                rd_data_d = rd_data_i;
                rd_pend_d = 1'b1;
            end else begin
                ovf_rd = 1'b1;
            end
        end
    end

    always_comb begin
        alu_pend_d = alu_pend_q & ~grant_alu;
        alu_data_d = alu_data_q;
        ovf_alu    = 1'b0;
        if (alu_out_vld_i) begin
            if (!alu_pend_d) begin
                alu_data_d = alu_out_i;
                alu_pend_d = 1'b1;
            end else begin
                ovf_alu = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_rd || grant_alu) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (tx_busy_i) begin
                    state_d = StDrain;
                end else if (timeout) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (!tx_busy_i) begin
                    state_d = msb_owed_q ? StReq : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_data_d  = tx_data_q;
        tx_vld_d   = tx_vld_q;
        msb_d      = msb_q;
        msb_owed_d = msb_owed_q;
        prio_rd_d  = prio_rd_q;
        to_set     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant_rd) begin
                    tx_data_d  = rd_data_q;
                    tx_vld_d   = 1'b1;
                    msb_owed_d = 1'b0;
                    prio_rd_d  = 1'b0;
                end else if (grant_alu) begin
                    // The slot is freed now, so the MSB is parked locally for the second byte.
                    tx_data_d  = alu_data_q[7:0];
                    tx_vld_d   = 1'b1;
                    msb_d      = alu_data_q[15:8];
                    msb_owed_d = 1'b1;
                    prio_rd_d  = 1'b1;
                end
            end
            StReq: begin
                if (tx_busy_i) begin
                    tx_vld_d = 1'b0;
                end else if (timeout) begin
                    tx_vld_d   = 1'b0;
                    msb_owed_d = 1'b0;
                    to_set     = 1'b1;
                end
            end
            StDrain: begin
                if (!tx_busy_i && msb_owed_q) begin
                    tx_data_d  = msb_q;
                    tx_vld_d   = 1'b1;
                    msb_owed_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ovf_d = ovf_rd | ovf_alu | (ovf_q & ~ovf_clr_i);
    assign to_d  = to_set | (to_q & ~ovf_clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q  <= '0;
            rd_pend_q  <= 1'b0;
            alu_data_q <= '0;
            alu_pend_q <= 1'b0;
            prio_rd_q  <= 1'b1;
            msb_q      <= '0;
            msb_owed_q <= 1'b0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            ovf_q      <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_pend_q  <= rd_pend_d;
            alu_data_q <= alu_data_d;
            alu_pend_q <= alu_pend_d;
            prio_rd_q  <= prio_rd_d;
            msb_q      <= msb_d;
            msb_owed_q <= msb_owed_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            ovf_q      <= ovf_d;
            to_q       <= to_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_vld_o   = tx_vld_q;
    assign ovf_err_o  = ovf_q;
    assign to_err_o   = to_q;
    assign arb_busy_o = rd_pend_q | alu_pend_q | (state_q != StIdle);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Randomized bench for tx_resp_arbiter: a UART busy responder plus a transaction-level
// expected-byte model driven by the round-robin priority rules.
module tb_tx_resp_arbiter;

    localparam int unsigned TimeoutCyc = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rd_data = '0;
    logic        rd_vld = 1'b0;
    logic [15:0] alu_out = '0;
    logic        alu_vld = 1'b0;
    logic        tx_busy = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        ovf_err;
    logic        to_err;
    logic        arb_busy;

    always #5 clk = ~clk;

    tx_resp_arbiter #(
        .TIMEOUT_CYC(TimeoutCyc),
        .CNT_W      (11)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_data_i    (rd_data),
        .rd_data_vld_i(rd_vld),
        .alu_out_i    (alu_out),
        .alu_out_vld_i(alu_vld),
        .tx_busy_i    (tx_busy),
        .ovf_clr_i    (ovf_clr),
        .tx_data_o    (tx_data),
        .tx_vld_o     (tx_vld),
        .ovf_err_o    (ovf_err),
        .to_err_o     (to_err),
        .arb_busy_o   (arb_busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // UART busy responder: raises busy a random delay after TX_VLD, holds it a random time.
    bit         resp_en = 1'b1;
    int         dly = 0, dly_tgt = 0, hold = 0, gap_cnt = 100, cur_gap = 100;
    bit         hold_first = 1'b0;
    logic [7:0] byte_q[$];
    int         gap_q[$];

    always @(negedge clk) begin
        if (!rst_n || !resp_en) begin
            tx_busy    = 1'b0;
            dly        = 0;
            hold       = 0;
            hold_first = 1'b0;
            gap_cnt    = 100;
        end else if (tx_busy) begin
            if (hold_first) begin
                check_eq("vld_drop", {31'd0, tx_vld}, 32'd0);
                hold_first = 1'b0;
            end
            hold--;
            if (hold <= 0) begin
                tx_busy = 1'b0;
                gap_cnt = 0;
            end
        end else begin
            if (gap_cnt < 100) gap_cnt++;
            if (tx_vld) begin
                if (dly == 0) cur_gap = gap_cnt;
                if (dly >= dly_tgt) begin
                    tx_busy    = 1'b1;
                    hold       = $urandom_range(2, 12);
                    hold_first = 1'b1;
                    byte_q.push_back(tx_data);
                    gap_q.push_back(cur_gap);
                    dly        = 0;
                    dly_tgt    = $urandom_range(0, 4);
                end else begin
                    dly++;
                end
            end
        end
    end

    // Reference model: expected byte stream and which source currently holds priority.
    logic [7:0] exp_q[$];
    bit         exp_msb[$];
    bit         prio_rd = 1'b1;

    task automatic model_rd(input logic [7:0] d);
        exp_q.push_back(d);
        exp_msb.push_back(1'b0);
        prio_rd = 1'b0;
    endtask

    task automatic model_alu(input logic [15:0] d);
        exp_q.push_back(d[7:0]);
        exp_msb.push_back(1'b0);
        exp_q.push_back(d[15:8]);
        exp_msb.push_back(1'b1);
        prio_rd = 1'b1;
    endtask

    task automatic drive(input bit dr, input logic [7:0] r, input bit da, input logic [15:0] a);
        @(negedge clk);
        rd_vld  = dr;
        rd_data = r;
        alu_vld = da;
        alu_out = a;
    endtask

    task automatic finish_episode(input string tag, input bit exp_ovf);
        int cyc = 0;
        drive(1'b0, 8'h00, 1'b0, 16'h0000);
        while (!(byte_q.size() == exp_q.size() && !arb_busy && !tx_busy && !tx_vld)
               && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_nbytes"}, byte_q.size(), exp_q.size());
        check_eq({tag, "_arb_busy"}, {31'd0, arb_busy}, 32'd0);
        foreach (exp_q[i]) begin
            check_eq({tag, "_byte"}, (i < byte_q.size()) ? {24'd0, byte_q[i]} : 32'hdead,
                     {24'd0, exp_q[i]});
            if (exp_msb[i])
                check_eq({tag, "_msb_gap"}, (i < gap_q.size()) ? gap_q[i] : -1, 1);
        end
        check_eq({tag, "_ovf"}, {31'd0, ovf_err}, {31'd0, exp_ovf});
        check_eq({tag, "_to"}, {31'd0, to_err}, 32'd0);
        if (exp_ovf) begin
            @(negedge clk);
            ovf_clr = 1'b1;
            @(negedge clk);
            ovf_clr = 1'b0;
            check_eq({tag, "_ovf_clr"}, {31'd0, ovf_err}, 32'd0);
        end
        byte_q.delete();
        gap_q.delete();
        exp_q.delete();
        exp_msb.delete();
    endtask

    task automatic ep_rd(input logic [7:0] r);
        drive(1'b1, r, 1'b0, 16'h0000);
        model_rd(r);
        finish_episode("rd", 1'b0);
    endtask

    task automatic ep_alu(input logic [15:0] a);
        drive(1'b0, 8'h00, 1'b1, a);
        model_alu(a);
        finish_episode("alu", 1'b0);
    endtask

    task automatic ep_both(input logic [7:0] r, input logic [15:0] a);
        drive(1'b1, r, 1'b1, a);
        if (prio_rd) begin
            model_rd(r);
            model_alu(a);
        end else begin
            model_alu(a);
            model_rd(r);
        end
        finish_episode("both", 1'b0);
    endtask

    // Second RD arrives while the first waits behind an ALU transfer and must be dropped.
    task automatic ep_ovf(input logic [7:0] r0, input logic [7:0] r1, input logic [15:0] a);
        drive(1'b0, 8'h00, 1'b1, a);
        drive(1'b0, 8'h00, 1'b0, 16'h0000);
        drive(1'b1, r0, 1'b0, 16'h0000);
        drive(1'b1, r1, 1'b0, 16'h0000);
        model_alu(a);
        model_rd(r0);
        finish_episode("ovf", 1'b1);
    endtask

    // Second RD lands in the first one's grant cycle and must be accepted.
    task automatic ep_accept(input logic [7:0] r0, input logic [7:0] r1);
        drive(1'b1, r0, 1'b0, 16'h0000);
        drive(1'b1, r1, 1'b0, 16'h0000);
        model_rd(r0);
        model_rd(r1);
        finish_episode("accept", 1'b0);
    endtask

    initial begin
        int vld_cnt;
        repeat (3) @(negedge clk);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
        check_eq("rst_ovf", {31'd0, ovf_err}, 32'd0);
        check_eq("rst_to", {31'd0, to_err}, 32'd0);
        check_eq("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        ep_rd(8'h5A);
        ep_alu(16'hBEEF);
        ep_both(8'h11, 16'h2233);
        ep_rd(8'h44);
        ep_both(8'h55, 16'h6677);
        ep_ovf(8'h01, 8'h02, 16'hC0DE);
        ep_accept(8'h03, 8'h04);

        for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 4))
                0: ep_rd(8'($urandom_range(0, 255)));
                1: ep_alu(16'($urandom_range(0, 65535)));
                2: ep_both(8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
                3: ep_ovf(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          16'($urandom_range(0, 65535)));
                default: ep_accept(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            endcase
        end

        // Reset in the middle of an ALU LSB request abandons the MSB.
        resp_en = 1'b0;
        drive(1'b0, 8'h00, 1'b1, 16'hA55A);
        drive(1'b0, 8'h00, 1'b0, 16'h0000);
        for (int i = 0; i < 10 && !tx_vld; i++) @(negedge clk);
        check_eq("mid_vld", {31'd0, tx_vld}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_data", {24'd0, tx_data}, 32'd0);
        check_eq("mid_rst_vld", {31'd0, tx_vld}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, arb_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prio_rd = 1'b1;
        vld_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_vld) vld_cnt++;
        end
        check_eq("post_rst_vld", vld_cnt, 0);
        check_eq("post_rst_busy", {31'd0, arb_busy}, 32'd0);

        // Busy never rises: timeout drops the request only when the feature is built.
        drive(1'b1, 8'h77, 1'b0, 16'h0000);
        drive(1'b0, 8'h00, 1'b0, 16'h0000);
        vld_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_vld) vld_cnt++;
        end
`ifdef TX_RESP_TIMEOUT_EN
        check_eq("to_vld_cycles", vld_cnt, TimeoutCyc);
        check_eq("to_err", {31'd0, to_err}, 32'd1);
        check_eq("to_arb_busy", {31'd0, arb_busy}, 32'd0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_eq("to_clr", {31'd0, to_err}, 32'd0);
`else
        check_eq("no_to_vld_cycles", vld_cnt, 40);
        check_eq("no_to_err", {31'd0, to_err}, 32'd0);
        check_eq("no_to_data", {24'd0, tx_data}, 32'h77);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
